fifo_rr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares one fifo (depth DEPTH, width WIDTH+ID_W) among N_REQ producers.

---
 rtl/fifo_rr_arbiter.sv | 89 ++++++++
 tb/tb_fifo_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter in front of a shared fifo: tags each accepted word with its source id,
// tracks committed occupancy itself and gates the consumer's pop so the fifo never over/underflows.
module fifo_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ*WIDTH-1:0]          data_i,
  output logic [N_REQ-1:0]                ack_o,
  output logic [$clog2(N_REQ)+WIDTH-1:0]  fifo_din_o,
  output logic                            fifo_wr_en_o,
  input  logic                            pop_i,
  output logic                            fifo_rd_en_o,
  output logic [$clog2(DEPTH):0]          level_o
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int LW   = $clog2(DEPTH) + 1;

  // Handshake: req_i[k] is a valid held with its data until ack_o[k]; ack_o[k] is the ready/accept
  // for that same cycle, so the word is taken at the edge where req_i[k] && ack_o[k] are both high.

  logic [ID_W-1:0]  rr_last_q;
  logic [LW-1:0]    level_q;
  logic [ID_W-1:0]  winner;
  logic [WIDTH-1:0] payload;
  logic             found;
  logic             can_grant;
  logic             grant;
  logic [LW:0]      occupancy;
  int               idx;

  // Search starts just after the last winner and wraps modulo N_REQ, so winner is always legal.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    payload = '0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(rr_last_q) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        winner  = ID_W'(idx);
        payload = data_i[idx*WIDTH +: WIDTH];
      end
    end
  end

  // The pending registered write counts as occupied; reads are deliberately not credited.
  assign occupancy = {1'b0, level_q} + (LW+1)'(fifo_wr_en_o);
  assign can_grant = occupancy < (LW+1)'(DEPTH);
  assign grant     = can_grant && found && !reset_i;

  always_comb begin
    ack_o = '0;
    if (grant) ack_o[winner] = 1'b1;
  end

  assign fifo_rd_en_o = pop_i && (level_q != '0) && !reset_i;
  assign level_o      = level_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_last_q    <= ID_W'(N_REQ - 1);
      level_q      <= '0;
      fifo_wr_en_o <= 1'b0;
      fifo_din_o   <= '0;
    end else begin
      level_q <= level_q + LW'(fifo_wr_en_o) - LW'(fifo_rd_en_o);
      if (grant) begin
        fifo_din_o   <= {winner, payload};
        fifo_wr_en_o <= 1'b1;
        rr_last_q    <= winner;
      end else begin
        fifo_wr_en_o <= 1'b0;
      end
    end
  end

  a_level_bound: assert property (@(posedge clk_i) disable iff (reset_i) level_q <= LW'(DEPTH));
  a_no_wr_full:  assert property (@(posedge clk_i) disable iff (reset_i)
                                  fifo_wr_en_o |-> level_q < LW'(DEPTH));
  a_no_rd_empty: assert property (@(posedge clk_i) disable iff (reset_i)
                                  fifo_rd_en_o |-> level_q != '0);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed vector table on a 4-requester instance, then a random
// scoreboard run on a 3-requester instance checking tags, order, occupancy and fairness.
module tb_fifo_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance
  logic        rst4;
  logic [3:0]  req4;
  logic [31:0] data4;
  logic [3:0]  ack4;
  logic [9:0]  din4;
  logic        wr4;
  logic        pop4;
  logic        rd4;
  logic [3:0]  lvl4;

  fifo_rr_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(8)) u_dut4 (
    .clk_i(clk), .reset_i(rst4), .req_i(req4), .data_i(data4), .ack_o(ack4),
    .fifo_din_o(din4), .fifo_wr_en_o(wr4), .pop_i(pop4), .fifo_rd_en_o(rd4), .level_o(lvl4)
  );

  // 3-requester instance
  logic        rst3;
  logic [2:0]  req3;
  logic [23:0] data3;
  logic [2:0]  ack3;
  logic [9:0]  din3;
  logic        wr3;
  logic        pop3;
  logic        rd3;
  logic [3:0]  lvl3;

  fifo_rr_arbiter #(.N_REQ(3), .WIDTH(8), .DEPTH(8)) u_dut3 (
    .clk_i(clk), .reset_i(rst3), .req_i(req3), .data_i(data3), .ack_o(ack3),
    .fifo_din_o(din3), .fifo_wr_en_o(wr3), .pop_i(pop3), .fifo_rd_en_o(rd3), .level_o(lvl3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       pop;
    logic [3:0] ack;
    logic       wr;
    logic [9:0] din;
    logic [3:0] lvl;
    logic       rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic pop, input logic [3:0] ack,
                     input logic wr, input logic [9:0] din, input logic [3:0] lvl, input logic rd);
    vec_t v;
    v.rst = rst; v.req = req; v.pop = pop; v.ack = ack;
    v.wr = wr; v.din = din; v.lvl = lvl; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    //   rst req      pop  ack      wr  din       lvl rd
    add(1, 4'b1111, 1, 4'b0000, 0, 10'h000, 0, 0);  // reset forces ack/rd low
    add(0, 4'b0001, 0, 4'b0001, 0, 10'h000, 0, 0);  // single req 0
    add(0, 4'b0000, 0, 4'b0000, 1, 10'h0A5, 0, 0);  // write strobe next cycle
    add(0, 4'b0000, 0, 4'b0000, 0, 10'h0A5, 1, 0);  // level 1 after write
    add(1, 4'b0000, 0, 4'b0000, 0, 10'h0A5, 1, 0);  // reset again
    add(0, 4'b1111, 0, 4'b0001, 0, 10'h000, 0, 0);  // fill: 0,1,2,3,0,1,2,3
    add(0, 4'b1111, 0, 4'b0010, 1, 10'h0A5, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 1, 10'h111, 1, 0);
    add(0, 4'b1111, 0, 4'b1000, 1, 10'h222, 2, 0);
    add(0, 4'b1111, 0, 4'b0001, 1, 10'h333, 3, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 10'h0A5, 4, 0);
    add(0, 4'b1111, 0, 4'b0100, 1, 10'h111, 5, 0);
    add(0, 4'b1111, 0, 4'b1000, 1, 10'h222, 6, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 10'h333, 7, 0);  // level+pending = 8: stop
    add(0, 4'b1111, 0, 4'b0000, 0, 10'h333, 8, 0);  // full
    add(0, 4'b1111, 1, 4'b0000, 0, 10'h333, 8, 1);  // one pop
    add(0, 4'b1111, 0, 4'b0001, 0, 10'h333, 7, 0);  // grant resumes at req 0
    add(0, 4'b1111, 0, 4'b0000, 1, 10'h0A5, 7, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 10'h0A5, 8, 0);  // back to 8
    add(1, 4'b1111, 0, 4'b0000, 0, 10'h0A5, 8, 0);  // reset
    add(0, 4'b0000, 1, 4'b0000, 0, 10'h000, 0, 0);  // pop on empty gated
    add(0, 4'b0100, 1, 4'b0100, 0, 10'h000, 0, 0);
    add(0, 4'b0100, 1, 4'b0100, 1, 10'h222, 0, 0);
    add(0, 4'b0100, 1, 4'b0100, 1, 10'h222, 1, 1);  // 1-in/1-out
    add(0, 4'b0000, 1, 4'b0000, 1, 10'h222, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 10'h222, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 10'h222, 0, 0);  // drained
    add(0, 4'b0010, 0, 4'b0010, 0, 10'h222, 0, 0);  // ack to req 1
    add(1, 4'b0010, 0, 4'b0000, 1, 10'h111, 0, 0);  // reset drops pending write
    add(0, 4'b1111, 0, 4'b0001, 0, 10'h000, 0, 0);  // first grant after reset: req 0
    add(0, 4'b0000, 0, 4'b0000, 1, 10'h0A5, 0, 0);
  endtask

  // ---------------- random run state ----------------
  localparam int RAND_CYCLES = 10000;
  localparam int DRAIN       = 300;
  logic [7:0] seq3[3];
  int         wait3[3];
  logic [2:0] acked_prev;
  int         model_lvl;

  initial begin
    rst4 = 1'b1; req4 = '0; pop4 = 1'b0; data4 = {8'h33, 8'h22, 8'h11, 8'hA5};
    rst3 = 1'b1; req3 = '0; pop3 = 1'b0; data3 = '0;
    build_table();
    repeat (2) @(posedge clk);

    // directed table: inputs driven after the edge, outputs checked at the falling edge
    foreach (vecs[i]) begin
      #1;
      rst4 = vecs[i].rst; req4 = vecs[i].req; pop4 = vecs[i].pop;
      @(negedge clk);
      check($sformatf("row%0d ack", i),   32'(ack4), 32'(vecs[i].ack));
      check($sformatf("row%0d wr_en", i), 32'(wr4),  32'(vecs[i].wr));
      check($sformatf("row%0d din", i),   32'(din4), 32'(vecs[i].din));
      check($sformatf("row%0d level", i), 32'(lvl4), 32'(vecs[i].lvl));
      check($sformatf("row%0d rd_en", i), 32'(rd4),  32'(vecs[i].rd));
      @(posedge clk);
    end
    req4 = '0; pop4 = 1'b0;

    // random scoreboard on the 3-requester instance
    for (int k = 0; k < 3; k++) begin seq3[k] = '0; wait3[k] = 0; end
    acked_prev = '0;
    model_lvl  = 0;
    @(posedge clk);
    #1 rst3 = 1'b0;
    for (int cyc = 0; cyc < RAND_CYCLES + DRAIN; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (acked_prev[k]) req3[k] = 1'b0;
        if (!req3[k] && cyc < RAND_CYCLES && $urandom_range(0, 1) == 1) begin
          req3[k] = 1'b1;
          data3[k*8 +: 8] = seq3[k];
          seq3[k] = seq3[k] + 8'd1;
        end
      end
      pop3 = (cyc >= RAND_CYCLES) ? 1'b1 : 1'($urandom_range(0, 1));

      @(negedge clk);
      check("rand level", 32'(lvl3), 32'(model_lvl));
      check("rand rd_en", 32'(rd3), 32'(pop3 && model_lvl != 0));
      check("rand ack onehot", 32'($onehot0(ack3)), 32'(1));
      check("rand ack unrequested", 32'(ack3 & ~req3), 32'(0));
      check("rand grant when space", 32'(ack3 != '0),
            32'((req3 != '0) && (model_lvl + int'(wr3) < 8)));
      if (wr3) begin
        if (exp_q.size() == 0) check("rand unexpected write", 32'(din3), 32'h3ff);
        else check("rand din", 32'(din3), 32'(exp_q.pop_front()));
      end
      for (int k = 0; k < 3; k++) begin
        if (ack3 != '0 && req3[k]) wait3[k]++;
        if (ack3[k]) begin
          check($sformatf("rand wait src%0d", k), 32'(wait3[k] <= 3), 32'(1));
          wait3[k] = 0;
          exp_q.push_back({2'(k), data3[k*8 +: 8]});
        end
      end
      acked_prev = ack3;
      model_lvl  = model_lvl + int'(wr3) - int'(rd3 && model_lvl != 0);
    end
    check("rand all reqs served", 32'(req3 & ~acked_prev), 32'(0));
    check("rand no words lost", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
